adder_rr_arbiter: RTL and testbench
===================================

// Module: adder_rr_arbiter
// PURPOSE
//  Shares one N-bit ripple adder datapath between NREQ requesters.
//  Round-robin arbitration, one registered result slot, valid/ready handshakes on both sides.
//  Sits between the requesting units and the single N-bit adder; returns sum, carry-out and requester id.
//  Sustains one add per cycle when the consumer never stalls.
// PARAMETERS
//  N     32  operand/sum width (>=1)
//  NREQ  4   number of requesters (2..8)
//  IDW   2   requester id width = clog2(NREQ); must be consistent with NREQ
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  req_valid  in   NREQ    bit r: requester r presents operands
//  req_ready  out  NREQ    one-hot grant; bit r high = requester r accepted this cycle
//  req_a      in   NREQ*N  operand A, requester r at [r*N +: N]
//  req_b      in   NREQ*N  operand B, requester r at [r*N +: N]
//  res_valid  out  1       result slot full
//  res_ready  in   1       consumer accepts result
//  res_sum    out  N       (a+b) mod 2^N of the granted request
//  res_cout   out  1       carry out of bit N-1
//  res_id     out  IDW     index of the requester that owns the result
// BEHAVIOUR
//  Reset: res_valid=0, res_sum=0, res_cout=0, res_id=0, state=EMPTY, last_grant=NREQ-1
//   (requester 0 has top priority after reset). req_ready=0 while rst is high.
//  State machine: EMPTY (no result held) / FULL (result held, res_valid=1).
//  slot_free = (state==EMPTY) | res_ready.
//  Arbitration (combinational): when slot_free, scan requesters starting at
//   last_grant+1 mod NREQ and wrap; first r with req_valid[r]=1 wins.
//   req_ready[r]=1 for the winner only; req_ready=0 for all when !slot_free or no valid.
//   req_ready may depend combinationally on req_valid and res_ready.
//  Transfer: handshake = req_valid[r] & req_ready[r] on rising clk edge.
//   Same edge: res_sum<=a_r+b_r[N-1:0], res_cout<=bit N of (N+1)-bit sum,
//   res_id<=r, last_grant<=r, state<=FULL.
//   Latency: result valid the cycle after acceptance (1 cycle).
//  Drain: res_valid & res_ready with no new grant -> state<=EMPTY; res_sum/cout/id hold last value.
//  Simultaneous drain + grant: old result leaves, new result loaded same edge, stays FULL (no bubble).
//  Backpressure: FULL & !res_ready -> no grant; res_sum/res_cout/res_id stable until drained.
//  last_grant changes only on a grant; an idle cycle does not advance priority.
//  Requester must hold req_valid and operands until granted; arbiter never drops a pending request.
//  Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ grants.
//  Arithmetic: unsigned, wrap modulo 2^N; overflow signalled only by res_cout.
//  Reset mid-operation: any held result is discarded, res_valid drops asynchronously, priority returns to 0.
// TESTING
//  1. N=32: only req0 valid, a=32'hFFFF_FFFF, b=1, res_ready=1 -> next cycle res_valid=1, sum=0, cout=1, id=0.
//  2. All 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
//  3. req2 granted, res_ready=0 for 3 cycles -> res_valid held, sum/id stable, req_ready=0 all cycles;
//     res_ready=1 -> drain + next grant on same edge.
//  4. Grant to req3, then req0 and req3 both valid -> req0 wins (wrap-around of rotating priority).
//  5. Slot FULL, rst pulsed mid-cycle -> res_valid=0 immediately; first grant after reset goes to req0.
//  6. Random valid/ready/operands, 10k cycles vs scoreboard (a+b, cout, id, per-requester order, no loss).

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin arbitration of NREQ requesters onto one shared
// N-bit adder, with a single registered result slot and valid/ready on both sides.
module adder_rr_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N-1:0]        res_sum,
    output logic                res_cout,
    output logic [IDW-1:0]      res_id
);

    localparam int unsigned SUMW = N + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_last_grant;
    logic [N-1:0]       r_sum;
    logic               r_cout;
    logic [IDW-1:0]     r_id;

    logic               w_slot_free;
    logic               w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic [IDW-1:0]     w_scan_idx;
    logic [NREQ-1:0]    w_req_ready;
    logic [N-1:0]       w_sel_a;
    logic [N-1:0]       w_sel_b;
    logic [SUMW-1:0]    w_sum_ext;

    // The slot can accept a new result when empty or when it drains this cycle.
    assign w_slot_free = (r_state == EMPTY) | res_ready;

    // Rotating-priority scan starting just after the last winner; no grant during reset.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        w_req_ready = '0;
        if (w_slot_free && !rst) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                w_scan_idx = IDW'((32'(r_last_grant) + i) % NREQ);
                if (!w_grant && req_valid[w_scan_idx]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = w_scan_idx;
                end
            end
        end
        if (w_grant) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Operand mux and the shared (N+1)-bit add of the winning request.
    always_comb begin
        w_sel_a   = req_a[32'(w_grant_idx) * N +: N];
        w_sel_b   = req_b[32'(w_grant_idx) * N +: N];
        w_sum_ext = {1'b0, w_sel_a} + {1'b0, w_sel_b};
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a grant always fills the slot; a drain without a grant empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && res_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    // Priority pointer moves only on a grant; reset makes requester 0 top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_grant) begin
            r_last_grant <= w_grant_idx;
        end
    end

    // Result slot payload; holds its value after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_id   <= '0;
        end else if (w_grant) begin
            r_sum  <= w_sum_ext[N-1:0];
            r_cout <= w_sum_ext[N];
            r_id   <= w_grant_idx;
        end
    end

    assign req_ready = w_req_ready;
    assign res_valid = (r_state == FULL);
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_id    = r_id;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbiter and its result slot.
module tb_adder_rr_arbiter;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic                res_valid;
    logic                res_ready;
    logic [N-1:0]        res_sum;
    logic                res_cout;
    logic [IDW-1:0]      res_id;

    int checks = 0;
    int errors = 0;

    adder_rr_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    // Hold reset across one rising edge, release 1 time unit after it.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        #2;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++;
        if (res_sum !== 32'h0 || res_cout !== 1'b0 || res_id !== 2'd0) begin
            errors++; $display("FAIL reset_payload got=%h/%b/%0d exp=0/0/0", res_sum, res_cout, res_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_carry();
        do_reset();
        req_valid     = 4'b0001;
        req_a[31:0]   = 32'hFFFF_FFFF;
        req_b[31:0]   = 32'h0000_0001;
        res_ready     = 1'b1;
        #4;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL carry_grant got=%b exp=0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        #4;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 32'h0 || res_cout !== 1'b1 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL carry_result got v=%b s=%h c=%b id=%0d exp v=1 s=0 c=1 id=0",
                     res_valid, res_sum, res_cout, res_id);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 32'h0 || res_cout !== 1'b1) begin
            errors++; $display("FAIL carry_drain got v=%b s=%h c=%b exp v=0 s=0 c=1", res_valid, res_sum, res_cout);
        end
    endtask

    task automatic test_all_valid();
        logic [N-1:0] av [NREQ];
        logic [N-1:0] bv [NREQ];
        logic [N:0]   exp_ext;
        int           prev;
        do_reset();
        for (int r = 0; r < int'(NREQ); r++) begin
            av[r] = 32'h1000_0000 * 32'(r + 1) + 32'h11;
            bv[r] = 32'h2000_0000 * 32'(r + 3);
            req_a[r*N +: N] = av[r];
            req_b[r*N +: N] = bv[r];
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #4;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                prev    = (k - 1) % 4;
                exp_ext = {1'b0, av[prev]} + {1'b0, bv[prev]};
                checks++;
                if (res_valid !== 1'b1 || res_id !== 2'(prev) || {res_cout, res_sum} !== exp_ext) begin
                    errors++;
                    $display("FAIL rr_result k=%0d got v=%b id=%0d cs=%h exp v=1 id=%0d cs=%h",
                             k, res_valid, res_id, {res_cout, res_sum}, prev, exp_ext);
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid      = 4'b0100;
        req_a[2*N +: N] = 32'd5;
        req_b[2*N +: N] = 32'd7;
        res_ready      = 1'b0;
        #4;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
        @(posedge clk);
        #1;
        req_valid     = 4'b0001;
        req_a[0 +: N] = 32'd10;
        req_b[0 +: N] = 32'd20;
        for (int c = 0; c < 3; c++) begin
            #4;
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_sum !== 32'd12 || res_id !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold c=%0d got rdy=%b v=%b s=%0d id=%0d exp rdy=0000 v=1 s=12 id=2",
                         c, req_ready, res_valid, res_sum, res_id);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        #4;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_drain_grant got=%b exp=0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        res_ready = 1'b0;
        #4;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 32'd30 || res_id !== 2'd0) begin
            errors++; $display("FAIL bp_no_bubble got v=%b s=%0d id=%0d exp v=1 s=30 id=0", res_valid, res_sum, res_id);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b1000;
        #4;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got=%b exp=1000", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        #4;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second got=%b exp=0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        #4;
        checks++;
        if (res_id !== 2'd0 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL wrap_third got id=%0d rdy=%b exp id=0 rdy=1000", res_id, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid       = 4'b0010;
        req_a[1*N +: N] = 32'd3;
        req_b[1*N +: N] = 32'd4;
        res_ready       = 1'b0;
        #4;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant got=%b exp=0010", req_ready); end
        @(posedge clk);
        #2;
        req_valid = 4'hF;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 32'd7) begin
            errors++; $display("FAIL rstmid_full got v=%b s=%0d exp v=1 s=7", res_valid, res_sum);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL rstmid_drop got v=%b rdy=%b exp v=0 rdy=0000", res_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        #3;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_prio got=%b exp=0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    // Random traffic checked against a transaction model: each requester has at most
    // one outstanding operation; the winner is the nearest pending requester after the
    // previous winner, and the slot holds the last accepted sum until consumed.
    task automatic test_random();
        bit           pend [NREQ];
        logic [N-1:0] av   [NREQ];
        logic [N-1:0] bv   [NREQ];
        int           grants [NREQ];
        int           m_last;
        bit           m_full;
        logic [N:0]   m_ext;
        int           m_id;
        int           win;
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        m_last = NREQ - 1;
        m_full = 1'b0;
        m_ext  = '0;
        m_id   = 0;
        for (int r = 0; r < int'(NREQ); r++) begin
            pend[r]   = 1'b0;
            av[r]     = '0;
            bv[r]     = '0;
            grants[r] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int r = 0; r < int'(NREQ); r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    av[r]   = $urandom;
                    bv[r]   = $urandom;
                    if ($urandom_range(0, 7) == 0) bv[r] = ~av[r] + 32'd1;
                end
                req_valid[r]    = pend[r];
                req_a[r*N +: N] = av[r];
                req_b[r*N +: N] = bv[r];
            end
            res_ready = ($urandom_range(0, 9) < 7);
            #4;
            win     = -1;
            exp_rdy = '0;
            if (!m_full || res_ready) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    if (win < 0 && pend[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (res_valid !== m_full) begin
                errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, res_valid, m_full);
            end
            if (m_full) begin
                checks++;
                if ({res_cout, res_sum} !== m_ext || res_id !== 2'(m_id)) begin
                    errors++;
                    $display("FAIL rand_result cyc=%0d got cs=%h id=%0d exp cs=%h id=%0d",
                             cyc, {res_cout, res_sum}, res_id, m_ext, m_id);
                end
            end
            @(posedge clk);
            if (win >= 0) begin
                m_full       = 1'b1;
                m_ext        = {1'b0, av[win]} + {1'b0, bv[win]};
                m_id         = win;
                m_last       = win;
                pend[win]    = 1'b0;
                grants[win]++;
            end else if (m_full && res_ready) begin
                m_full = 1'b0;
            end
            #1;
        end
        for (int r = 0; r < int'(NREQ); r++) begin
            checks++;
            if (grants[r] < 100) begin
                errors++; $display("FAIL rand_starve req=%0d got=%0d grants exp>=100", r, grants[r]);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_carry();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
